// File: rtl/pb_event_decoder.sv
// Debounces the active-low button and classifies gestures as short, long or double presses.
// Latency: pressed/held DEBOUNCE_CYC+2 cycles after PB settles. Backpressure: none, every output is a registered pulse or level.
module pb_event_decoder #(
    parameter int CNT_W        = 24,
    parameter int DEBOUNCE_CYC = 50000,
    parameter int LONG_CYC     = 10000000,
    parameter int DBL_GAP_CYC  = 12500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic PB,
    output logic held,
    output logic pressed,
    output logic released,
    output logic short_press,
    output logic long_press,
    output logic double_press
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DBL_GAP_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        HELD,
        LONG_HELD,
        WAIT_2ND,
        HELD2
    } state_t;

    state_t            state;
    logic              sync1;
    logic              sync;
    logic              db;
    logic              db_q;
    logic              db_fall;
    logic              db_rise;
    logic [CNT_W-1:0]  deb_cnt;
    logic [CNT_W-1:0]  hold_cnt;
    logic [CNT_W-1:0]  gap_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync  <= 1'b1;
        end else begin
            sync1 <= PB;
            sync  <= sync1;
        end
    end

    // Any agreeing cycle restarts the count, so a bounce never accumulates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db      <= 1'b1;
            deb_cnt <= '0;
        end else if (sync != db) begin
            if (deb_cnt == DEB_LAST) begin
                db      <= sync;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + CNT_W'(1);
            end
        end else begin
            deb_cnt <= '0;
        end
    end

    assign db_fall = db_q & ~db;
    assign db_rise = ~db_q & db;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_q     <= 1'b1;
            held     <= 1'b0;
            pressed  <= 1'b0;
            released <= 1'b0;
        end else begin
            db_q     <= db;
            held     <= ~db;
            pressed  <= db_fall;
            released <= db_rise;
        end
    end

    // Gesture tracker advances on the same edge that raises pressed/released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            hold_cnt     <= '0;
            gap_cnt      <= '0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_press <= 1'b0;
        end else begin
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_press <= 1'b0;
            case (state)
                IDLE: begin
                    if (db_fall) begin
                        state    <= HELD;
                        hold_cnt <= '0;
                    end
                end
                HELD: begin
                    if (db_rise) begin
                        state   <= WAIT_2ND;
                        gap_cnt <= '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        long_press <= 1'b1;
                        state      <= LONG_HELD;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                LONG_HELD: begin
                    if (db_rise) begin
                        state <= IDLE;
                    end
                end
                WAIT_2ND: begin
                    // A press landing on the expiry cycle still counts as a double.
                    if (db_fall) begin
                        double_press <= 1'b1;
                        state        <= HELD2;
                    end else if (gap_cnt == GAP_LAST) begin
                        short_press <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + CNT_W'(1);
                    end
                end
                HELD2: begin
                    if (db_rise) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pb_event_decoder.sv
// Scoreboard bench for pb_event_decoder: timestamp-based gesture model feeds an expected-pulse queue.
module tb_pb_event_decoder;

    localparam int DEB = 4;
    localparam int LNG = 20;
    localparam int GAP = 10;

    logic clk = 1'b0;
    logic rst_n;
    logic pb;
    logic held, pressed, released, short_press, long_press, double_press;

    pb_event_decoder #(
        .CNT_W(8), .DEBOUNCE_CYC(DEB), .LONG_CYC(LNG), .DBL_GAP_CYC(GAP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .PB(pb),
        .held(held), .pressed(pressed), .released(released),
        .short_press(short_press), .long_press(long_press), .double_press(double_press)
    );

    always #5 clk = ~clk;

    typedef struct { int t; logic [4:0] m; } exp_t;
    typedef struct { int t; logic v; } pend_t;

    exp_t  exp_q[$];
    pend_t pend[$];
    int    cyc = 0;
    logic  held_m = 1'b0;

    int mon_checks = 0, mon_errs = 0, dir_checks = 0, dir_errs = 0;
    int n_pr = 0, n_rl = 0, n_sh = 0, n_lg = 0, n_db = 0;
    int t_pr = 0, t_rl = 0, t_sh = 0, t_lg = 0, t_db = 0;
    logic lg_held = 1'b0;

    // Reference model: a level flips after DEB consecutive differing raw samples and
    // shows up three edges later; gestures are classified from event timestamps.
    initial begin
        logic mdb;
        int   run, gst, tp, tr, ev;
        logic [4:0] m;
        mdb = 1'b1; run = 0; gst = 0; tp = 0; tr = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                mdb = 1'b1; run = 0; gst = 0; held_m = 1'b0;
                pend.delete();
            end else begin
                if (pb != mdb) begin
                    run++;
                    if (run == DEB) begin
                        mdb = pb;
                        run = 0;
                        pend.push_back('{cyc + 3, pb});
                    end
                end else begin
                    run = 0;
                end
                ev = 0;
                if (pend.size() > 0 && pend[0].t == cyc) begin
                    ev = pend[0].v ? 2 : 1;
                    void'(pend.pop_front());
                end
                m = '0;
                if (ev == 1) begin m[4] = 1'b1; held_m = 1'b1; end
                if (ev == 2) begin m[3] = 1'b1; held_m = 1'b0; end
                // gst: 0 idle, 1 first hold, 2 long hold, 3 waiting for second press, 4 second hold
                case (gst)
                    0: if (ev == 1) begin gst = 1; tp = cyc; end
                    1: if (ev == 2) begin gst = 3; tr = cyc; end
                       else if (cyc - tp == LNG) begin m[1] = 1'b1; gst = 2; end
                    2: if (ev == 2) gst = 0;
                    3: if (ev == 1) begin m[0] = 1'b1; gst = 4; end
                       else if (cyc - tr == GAP) begin m[2] = 1'b1; gst = 0; end
                    4: if (ev == 2) gst = 0;
                    default: gst = 0;
                endcase
                if (m != 0) exp_q.push_back('{cyc, m});
            end
        end
    end

    // Monitor: pops an expectation whenever the DUT shows any pulse.
    initial begin
        logic [4:0] m;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_checks++;
                if ({held, pressed, released, short_press, long_press, double_press} != 6'b0) begin
                    mon_errs++;
                    $display("FAIL reset_outputs cyc=%0d got=%b required=000000", cyc,
                             {held, pressed, released, short_press, long_press, double_press});
                end
                exp_q.delete();
            end else begin
                m = {pressed, released, short_press, long_press, double_press};
                while (exp_q.size() > 0 && exp_q[0].t < cyc) begin
                    mon_checks++;
                    mon_errs++;
                    $display("FAIL missed_pulse cyc=%0d required mask=%b at cyc %0d", cyc, exp_q[0].m, exp_q[0].t);
                    void'(exp_q.pop_front());
                end
                if (m != 0) begin
                    mon_checks++;
                    if (exp_q.size() == 0) begin
                        mon_errs++;
                        $display("FAIL unexpected_pulse cyc=%0d got mask=%b required none", cyc, m);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.t != cyc || e.m != m) begin
                            mon_errs++;
                            $display("FAIL pulse cyc=%0d got mask=%b required mask=%b at cyc %0d", cyc, m, e.m, e.t);
                        end
                    end
                    if (m[4]) begin n_pr++; t_pr = cyc; end
                    if (m[3]) begin n_rl++; t_rl = cyc; end
                    if (m[2]) begin n_sh++; t_sh = cyc; end
                    if (m[1]) begin n_lg++; t_lg = cyc; lg_held = held; end
                    if (m[0]) begin n_db++; t_db = cyc; end
                end
                mon_checks++;
                if (held !== held_m) begin
                    mon_errs++;
                    $display("FAIL held cyc=%0d got=%b required=%b", cyc, held, held_m);
                end
            end
        end
    end

    task automatic drive(input logic v, input int n);
        repeat (n) begin
            pb = v;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic dchk(input string name, input int act, input int req);
        dir_checks++;
        if (act != req) begin
            dir_errs++;
            $display("FAIL %s got=%0d required=%0d", name, act, req);
        end
    endtask

    initial begin
        int f, b_pr, b_rl, b_sh, b_lg, b_db;
        rst_n = 1'b0;
        pb    = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        b_pr = n_pr; b_rl = n_rl;
        drive(1'b1, 50);
        dchk("idle_no_press", n_pr - b_pr, 0);
        dchk("idle_no_release", n_rl - b_rl, 0);
        dchk("idle_held", int'(held), 0);

        b_pr = n_pr;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 3);
            drive(1'b1, 1);
        end
        drive(1'b1, 10);
        dchk("bounce_no_press", n_pr - b_pr, 0);
        dchk("bounce_held", int'(held), 0);

        b_pr = n_pr; b_rl = n_rl; b_sh = n_sh; b_lg = n_lg; b_db = n_db;
        f = cyc + 1;
        drive(1'b0, 10);
        drive(1'b1, 30);
        dchk("short_press_count", n_pr - b_pr, 1);
        dchk("short_press_latency", t_pr - f, DEB + 2);
        dchk("short_release_count", n_rl - b_rl, 1);
        dchk("short_count", n_sh - b_sh, 1);
        dchk("short_after_release", t_sh - t_rl, GAP);
        dchk("short_no_long_dbl", (n_lg - b_lg) + (n_db - b_db), 0);

        b_rl = n_rl; b_sh = n_sh; b_lg = n_lg;
        drive(1'b0, 40);
        drive(1'b1, 30);
        dchk("long_count", n_lg - b_lg, 1);
        dchk("long_after_press", t_lg - t_pr, LNG);
        dchk("long_held_level", int'(lg_held), 1);
        dchk("long_release_count", n_rl - b_rl, 1);
        dchk("long_no_short", n_sh - b_sh, 0);

        b_pr = n_pr; b_sh = n_sh; b_db = n_db;
        drive(1'b0, 10);
        drive(1'b1, 5);
        drive(1'b0, 10);
        drive(1'b1, 30);
        dchk("double_count", n_db - b_db, 1);
        dchk("double_with_press", t_db - t_pr, 0);
        dchk("double_press_count", n_pr - b_pr, 2);
        dchk("double_no_short", n_sh - b_sh, 0);

        b_sh = n_sh; b_db = n_db;
        drive(1'b0, 10);
        drive(1'b1, 10);
        drive(1'b0, 10);
        drive(1'b1, 30);
        dchk("expiry_tie_double", n_db - b_db, 1);
        dchk("expiry_tie_no_short", n_sh - b_sh, 0);

        b_sh = n_sh; b_db = n_db;
        drive(1'b0, 10);
        drive(1'b1, 11);
        drive(1'b0, 10);
        drive(1'b1, 30);
        dchk("gap_past_expiry_short", n_sh - b_sh, 2);
        dchk("gap_past_expiry_no_double", n_db - b_db, 0);

        b_sh = n_sh;
        drive(1'b0, 10);
        drive(1'b1, 10);
        rst_n = 1'b0;
        drive(1'b1, 3);
        rst_n = 1'b1;
        drive(1'b1, 30);
        dchk("reset_wait_no_short", n_sh - b_sh, 0);
        dchk("reset_wait_held", int'(held), 0);
        drive(1'b0, 10);
        drive(1'b1, 30);
        dchk("reset_then_short", n_sh - b_sh, 1);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                drive(1'($urandom_range(0, 1)), 2);
                rst_n = 1'b1;
            end
            drive(1'($urandom_range(0, 1)), $urandom_range(1, 25));
        end
        drive(1'b1, 40);
        dchk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", mon_checks + dir_checks, mon_errs + dir_errs);
        $finish;
    end

endmodule

// File: doc/pb_event_decoder.md
Name: pb_event_decoder

Overview:
- Turns the raw active-low push-button input into debounced, classified button events: press, release, short press, long press and double press.
- Pairs with the release-edge detector. That block reports only the release edge of the synchronized button; this block handles the press side and interprets the whole gesture.
- Sits between the board button pin and the mode/steer-enable control logic.
- All outputs are registered, single-clock-domain signals.

Parameters:
- CNT_W, 24: width of the debounce, hold and gap counters.
- DEBOUNCE_CYC, 50000: number of consecutive cycles a synchronized level must differ from the debounced state before that state flips. Legal range is 1 to 2^CNT_W-1.
- LONG_CYC, 10000000: cycles from the pressed pulse to the long_press pulse.
- DBL_GAP_CYC, 12500000: maximum release-to-press gap, in cycles, that still counts as a double press.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- PB  input  1  raw button, asynchronous to clk; 0 = pressed, 1 = idle
- held  output  1  level; debounced button is pressed
- pressed  output  1  1-cycle pulse on debounced press
- released  output  1  1-cycle pulse on debounced release
- short_press  output  1  1-cycle pulse; single press completed
- long_press  output  1  1-cycle pulse; hold reached LONG_CYC
- double_press  output  1  1-cycle pulse; second press arrived within the gap window

Behaviour:
- Reset (asynchronous, rst_n low):
  - Both synchronizer flops = 1 and the debounced state db = 1 (idle).
  - All counters = 0, FSM = IDLE.
  - All outputs = 0.
  - Reset mid-gesture discards the gesture; no pulse is emitted at or after reset release.
- Synchronizer: two-flop chain on PB; the second flop output is sync.
- Debounce:
  - While sync != db, deb_cnt increments each cycle.
  - Any cycle with sync == db clears deb_cnt to 0, so a bounce restarts the count.
  - When deb_cnt == DEBOUNCE_CYC-1 and sync != db still holds, db <= sync and deb_cnt <= 0.
- Edge pulses:
  - pressed is high for exactly the one cycle after db goes 1->0.
  - released is high for exactly the one cycle after db goes 0->1.
  - held = ~db, registered alongside the pulses, so held rises in the same cycle as pressed.
  - End-to-end latency: a clean PB fall sampled at edge k produces pressed high after edge k+DEBOUNCE_CYC+2.
- FSM (registered; transitions on the same edge that raises pressed/released):
  - IDLE: on db press -> HELD, hold_cnt = 0.
  - HELD: hold_cnt increments each cycle.
    - When hold_cnt == LONG_CYC-1 with db still pressed: long_press pulse, -> LONG_HELD.
    - On db release first: -> WAIT_2ND, gap_cnt = 0.
    - Net effect: long_press rises exactly LONG_CYC cycles after pressed rose.
  - LONG_HELD: on db release -> IDLE. No short_press or double_press is emitted.
  - WAIT_2ND: gap_cnt increments each cycle.
    - On db press: double_press pulse (same cycle as pressed), -> HELD2.
    - Otherwise, when gap_cnt == DBL_GAP_CYC-1: short_press pulse, -> IDLE.
    - short_press rises exactly DBL_GAP_CYC cycles after released rose.
    - If the press and the gap expiry fall on the same cycle, the press wins: double_press, no short_press.
  - HELD2: waits for db release -> IDLE. No long_press is emitted, however long the hold.
- Counters: hold_cnt and gap_cnt count only in their own state and are cleared on entry. They never wrap, because expiry leaves the state.
- Exclusivity: at most one of short_press, long_press, double_press is high in any cycle.
- Each gesture emits exactly one classification: short, long or double.

Test Plan (DEBOUNCE_CYC=4, LONG_CYC=20, DBL_GAP_CYC=10, CNT_W=8):
- Reset: hold rst_n low with PB=0 -> all outputs 0. Release rst_n, PB=1 for 50 cycles -> no pulses, held=0.
- Bounce rejection: PB toggles 3 cycles low / 1 cycle high, 10 times -> pressed never asserts, held stays 0.
- Clean short press: PB low 10 cycles, then high:
  - pressed rises 6 cycles after the first low sample;
  - released fires once;
  - short_press rises exactly 10 cycles after released;
  - no long_press or double_press.
- Long press: PB low 40 cycles:
  - long_press rises exactly 20 cycles after pressed, held=1 throughout;
  - on release, released pulses and no short_press follows.
- Double press: two 10-cycle presses with a 5-cycle high gap:
  - double_press coincides with the second pressed pulse;
  - no short_press at any point;
  - return to IDLE after the second release.
- Edge cases:
  - Second press whose debounced edge lands exactly at gap expiry -> double_press, not short_press.
  - rst_n asserted 3 cycles into WAIT_2ND -> no short_press, FSM back in IDLE, held=0.
